pip_stage_reg: RTL and testbench
================================

# pip_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, an optional skid buffer, synchronous flush with bubble insertion, and saturating stall and bubble counters. It replaces the fixed-field pipeline registers between CPU stages (F/D, D/E, E/M, M/W). The payload is one packed vector of width DW, and each stage instance packs its own fields. Back-pressure is expressed with ready/valid handshakes instead of a bare write-enable.

## Interface
- DW, 32: payload width in bits, minimum 1.
- NOP_VALUE, {DW{1'b0}}: payload driven on out_data whenever the stage holds no valid entry.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of each performance counter.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  DW  upstream payload.
- flush  in  1  synchronous kill of all held entries and of any same-cycle input.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  DW  head payload.
- stall_cnt  out  CNT_W  number of cycles with out_valid & !out_ready, saturating.
- bubble_cnt  out  CNT_W  number of cycles with !out_valid & out_ready, saturating.

## Operation
- Input handshake: in_fire = in_valid & in_ready & !flush.
- Output handshake: out_fire = out_valid & out_ready.
- State: main entry (m_v, m_d). When SKID=1, also a skid entry (s_v, s_d).
- out_valid = m_v.
- out_data = m_d when m_v = 1, otherwise NOP_VALUE. This applies to both the SKID=1 and SKID=0 variants.
- SKID=0: in_ready = out_ready | !m_v. On in_fire, m_d <= in_data and m_v <= 1. Otherwise, on out_fire, m_v <= 0.
- SKID=1: in_ready is a register, equal to !s_v after every edge. Per cycle, take the first matching case:
  - flush: m_v, s_v <= 0; in_ready <= 1; m_d, s_d <= NOP_VALUE.
  - s_v & out_ready: main <= skid; s_v <= 0. in_ready was 0, so no input is taken.
  - in_fire & (!m_v | out_ready): main <= input.
  - in_fire & m_v & !out_ready: skid <= input; in_ready <= 0.
  - out_fire with no in_fire: m_v <= 0.
  - otherwise: hold.
- Ordering is strict FIFO. No entry is dropped except by flush, and none is duplicated.
- Flush is synchronous and takes priority over every load.
  - An output that fires in the flush cycle counts as consumed.
  - Input presented in the flush cycle is discarded, and the upstream stage sees no handshake.
- Counters increment by 1 per qualifying cycle and stick at 2^CNT_W-1. Only reset clears them; flush does not.
- Reset values: out_valid 0; out_data NOP_VALUE; in_ready 1 when SKID=1, and out_ready | 1 = 1 when SKID=0; stall_cnt 0; bubble_cnt 0; s_v 0.
- Reset is asynchronous. It takes effect immediately, mid-transfer included, and dominates flush.

## Timing
- Latency: 1 cycle from in_fire to out_valid, for both SKID values.
- Throughput: 1 entry per cycle whenever out_ready is held high.
- SKID=1:
  - in_ready falls the cycle after the skid buffer is loaded.
  - in_ready rises the cycle after the skid buffer drains into main.
  - No combinational path runs from out_ready to in_ready.
- SKID=0: combinational path from out_ready to in_ready.
- Flush at edge N: out_valid = 0 and out_data = NOP_VALUE from edge N until the next in_fire. When SKID=1, in_ready = 1 after edge N.
- Reset release: the first accepting edge is the first rising clk edge after reset goes high.

## Test plan
- Streaming, SKID=1, DW=32, out_ready = 1: push 0x11, 0x22, 0x33 on consecutive cycles -> out_data shows 0x11, 0x22, 0x33 on the 3 following cycles; in_ready stays 1; stall_cnt stays 0.
- Back-pressure, SKID=1: push 0xA, then 0xB while out_ready = 0 -> 0xB goes to the skid buffer and in_ready = 0 the next cycle; hold out_ready = 0 for 4 cycles -> stall_cnt = 4. Then set out_ready = 1 -> 0xA, then 0xB, and in_ready returns to 1.
- Flush: skid buffer full (0xA, 0xB) and in_valid = 1 with 0xC, assert flush for one cycle -> out_valid = 0, out_data = NOP_VALUE, in_ready = 1, and 0xC is never output. Counters are unchanged by the flush.
- SKID=0: out_valid = 1, out_ready = 0 -> in_ready = 0 in the same cycle. Raise out_ready -> in_ready = 1 in the same cycle, and the new entry replaces the old one at the next edge.
- Saturation, CNT_W=3: idle 10 cycles with out_ready = 1 -> bubble_cnt = 7 and stays at 7.
- Asynchronous reset: drop reset between clock edges while out_valid = 1 -> out_valid = 0, out_data = NOP_VALUE and counters = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/pip_stage_reg.sv
// pip_stage_reg: valid/ready pipeline register with optional skid entry,
// synchronous flush and saturating stall/bubble counters.
module pip_stage_reg #(
    parameter int unsigned   DW        = 32,
    parameter logic [DW-1:0] NOP_VALUE = {DW{1'b0}},
    parameter bit            SKID      = 1'b1,
    parameter int unsigned   CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic          main_v;
    logic [DW-1:0] main_data;
    logic          in_fire;
    logic          out_fire;

    assign in_fire   = in_valid & in_ready & ~flush;
    assign out_fire  = main_v & out_ready;
    assign out_valid = main_v;
    assign out_data  = main_v ? main_data : NOP_VALUE;

    if (SKID) begin : g_skid
        logic          main_v_q, main_v_d;
        logic          skid_v_q, skid_v_d;
        logic          rdy_q, rdy_d;
        logic [DW-1:0] main_q, main_d;
        logic [DW-1:0] skid_q, skid_d;

        // Priority chain: flush, skid drain, direct load, skid load, drain.
        always_comb begin
            main_v_d = main_v_q;
            main_d   = main_q;
            skid_v_d = skid_v_q;
            skid_d   = skid_q;
            rdy_d    = rdy_q;
            if (flush) begin
                main_v_d = 1'b0;
                skid_v_d = 1'b0;
                main_d   = NOP_VALUE;
                skid_d   = NOP_VALUE;
                rdy_d    = 1'b1;
            end else if (skid_v_q && out_ready) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
                rdy_d    = 1'b1;
            end else if (in_fire && (!main_v_q || out_ready)) begin
                main_v_d = 1'b1;
                main_d   = in_data;
            end else if (in_fire) begin
                skid_v_d = 1'b1;
                skid_d   = in_data;
                rdy_d    = 1'b0;
            end else if (out_fire) begin
                main_v_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                main_v_q <= 1'b0;
                main_q   <= NOP_VALUE;
                skid_v_q <= 1'b0;
                skid_q   <= NOP_VALUE;
                rdy_q    <= 1'b1;
            end else begin
                main_v_q <= main_v_d;
                main_q   <= main_d;
                skid_v_q <= skid_v_d;
                skid_q   <= skid_d;
                rdy_q    <= rdy_d;
            end
        end

        assign main_v    = main_v_q;
        assign main_data = main_q;
        assign in_ready  = rdy_q;
    end else begin : g_flop
        logic          main_v_q, main_v_d;
        logic [DW-1:0] main_q, main_d;

        always_comb begin
            main_v_d = main_v_q;
            main_d   = main_q;
            if (flush) begin
                main_v_d = 1'b0;
                main_d   = NOP_VALUE;
            end else if (in_fire) begin
                main_v_d = 1'b1;
                main_d   = in_data;
            end else if (out_fire) begin
                main_v_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                main_v_q <= 1'b0;
                main_q   <= NOP_VALUE;
            end else begin
                main_v_q <= main_v_d;
                main_q   <= main_d;
            end
        end

        assign main_v    = main_v_q;
        assign main_data = main_q;
        assign in_ready  = out_ready | ~main_v_q;
    end

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (main_v && !out_ready && stall_q != CNT_MAX)
            stall_d = stall_q + CNT_W'(1);
        if (!main_v && out_ready && bubble_q != CNT_MAX)
            bubble_d = bubble_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pip_stage_reg.sv
// tb_pip_stage_reg: two instances (skid/CNT_W=16 and flop/CNT_W=3)
// checked against a FIFO-level reference model every cycle.
module tb_pip_stage_reg;

    localparam logic [31:0] NOP1 = 32'h0000_0013;
    localparam logic [7:0]  NOP0 = 8'h5A;
    localparam int          MAX1 = 65535;
    localparam int          MAX0 = 7;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv1, ir1, fl1, ov1, or1;
    logic [31:0] d1, od1;
    logic [15:0] sc1, bc1;

    logic        iv0, ir0, fl0, ov0, or0;
    logic [7:0]  d0, od0;
    logic [2:0]  sc0, bc0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pip_stage_reg #(
        .DW(32), .NOP_VALUE(NOP1), .SKID(1'b1), .CNT_W(16)
    ) dut1 (
        .clk(clk), .reset(rst_n),
        .in_valid(iv1), .in_ready(ir1), .in_data(d1),
        .flush(fl1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .stall_cnt(sc1), .bubble_cnt(bc1)
    );

    pip_stage_reg #(
        .DW(8), .NOP_VALUE(NOP0), .SKID(1'b0), .CNT_W(3)
    ) dut0 (
        .clk(clk), .reset(rst_n),
        .in_valid(iv0), .in_ready(ir0), .in_data(d0),
        .flush(fl0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .stall_cnt(sc0), .bubble_cnt(bc0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 (skid) or 1 (flop).
    logic [31:0] q1[$];
    logic [7:0]  q0[$];
    int st1 = 0, bu1 = 0, st0 = 0, bu0 = 0;
    bit m_ir, m_ov, m_if, m_of;

    always @(negedge rst_n) begin
        q1.delete();
        q0.delete();
        st1 = 0; bu1 = 0; st0 = 0; bu0 = 0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_ov = q1.size() != 0;
            m_ir = q1.size() < 2;
            m_if = iv1 && m_ir && !fl1;
            m_of = m_ov && or1;
            if (m_ov && !or1 && st1 < MAX1) st1++;
            if (!m_ov && or1 && bu1 < MAX1) bu1++;
            if (fl1) q1.delete();
            else begin
                if (m_of) void'(q1.pop_front());
                if (m_if) q1.push_back(d1);
            end

            m_ov = q0.size() != 0;
            m_ir = or0 || q0.size() == 0;
            m_if = iv0 && m_ir && !fl0;
            m_of = m_ov && or0;
            if (m_ov && !or0 && st0 < MAX0) st0++;
            if (!m_ov && or0 && bu0 < MAX0) bu0++;
            if (fl0) q0.delete();
            else begin
                if (m_of) void'(q0.pop_front());
                if (m_if) q0.push_back(d0);
            end
        end
    end

    always @(negedge clk) begin
        chk("ov1", ov1, q1.size() != 0);
        chk("od1", od1, (q1.size() != 0) ? q1[0] : NOP1);
        chk("ir1", ir1, q1.size() < 2);
        chk("sc1", sc1, st1);
        chk("bc1", bc1, bu1);
        chk("ov0", ov0, q0.size() != 0);
        chk("od0", od0, (q0.size() != 0) ? q0[0] : NOP0);
        chk("ir0", ir0, or0 || q0.size() == 0);
        chk("sc0", sc0, st0);
        chk("bc0", bc0, bu0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycles(input int n, input int p);
        for (int i = 0; i < n; i++) begin
            iv1 = $urandom_range(0, 3) != 0;
            d1  = $urandom;
            or1 = $urandom_range(0, 3) < p;
            fl1 = $urandom_range(0, 31) == 0;
            iv0 = $urandom_range(0, 3) != 0;
            d0  = 8'($urandom);
            or0 = $urandom_range(0, 3) < p;
            fl0 = $urandom_range(0, 31) == 0;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv1 = 0; d1 = '0; or1 = 0; fl1 = 0;
        iv0 = 0; d0 = '0; or0 = 0; fl0 = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_ov1", ov1, 1'b0);
        chk("rst_od1", od1, NOP1);
        chk("rst_ir1", ir1, 1'b1);
        chk("rst_ir0", ir0, 1'b1);
        chk("rst_od0", od0, NOP0);
        tick();

        // streaming through the skid instance
        iv1 = 1; or1 = 1; d1 = 32'h11; tick();
        chk("str_11", od1, 32'h11);
        d1 = 32'h22; tick();
        chk("str_22", od1, 32'h22);
        d1 = 32'h33; tick();
        chk("str_33", od1, 32'h33);
        chk("str_ir", ir1, 1'b1);
        chk("str_sc", sc1, 0);
        iv1 = 0; tick();
        chk("str_end", ov1, 1'b0);

        // back-pressure fills the skid entry
        or1 = 0; iv1 = 1; d1 = 32'hA; tick();
        d1 = 32'hB; tick();
        chk("bp_ir0", ir1, 1'b0);
        iv1 = 0;
        repeat (3) tick();
        chk("bp_sc4", sc1, 4);
        chk("bp_hA", od1, 32'hA);
        or1 = 1; tick();
        chk("bp_B", od1, 32'hB);
        chk("bp_ir1", ir1, 1'b1);
        tick();
        chk("bp_nop", od1, NOP1);

        // flush with skid full and input pending
        or1 = 0; iv1 = 1; d1 = 32'hA; tick();
        d1 = 32'hB; tick();
        d1 = 32'hC; fl1 = 1; tick();
        chk("fl_ov", ov1, 1'b0);
        chk("fl_od", od1, NOP1);
        chk("fl_ir", ir1, 1'b1);
        chk("fl_sc", sc1, 6);
        fl1 = 0; iv1 = 0; or1 = 1; tick();
        chk("fl_noC", ov1, 1'b0);
        or1 = 0;

        // bubble counter saturation on the 3-bit instance
        or0 = 1;
        repeat (10) tick();
        chk("sat_7", bc0, 7);
        repeat (2) tick();
        chk("sat_hold", bc0, 7);

        // combinational in_ready on the flop instance
        or0 = 0; iv0 = 1; d0 = 8'h05; tick();
        chk("s0_od5", od0, 8'h05);
        chk("s0_ir0", ir0, 1'b0);
        or0 = 1; d0 = 8'h06; #1;
        chk("s0_ir1", ir0, 1'b1);
        tick();
        chk("s0_od6", od0, 8'h06);
        iv0 = 0; tick();
        chk("s0_nop", od0, NOP0);

        rnd_cycles(500, 1);
        rnd_cycles(500, 2);
        rnd_cycles(500, 4);

        // asynchronous reset between edges with valid entries held
        fl1 = 0; fl0 = 0;
        iv1 = 1; d1 = 32'hDEAD_BEEF; or1 = 0;
        iv0 = 1; d0 = 8'h77; or0 = 0;
        tick();
        chk("ar_pre1", ov1, 1'b1);
        chk("ar_pre0", ov0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov1", ov1, 1'b0);
        chk("ar_od1", od1, NOP1);
        chk("ar_ir1", ir1, 1'b1);
        chk("ar_sc1", sc1, 0);
        chk("ar_bc1", bc1, 0);
        chk("ar_ov0", ov0, 1'b0);
        chk("ar_od0", od0, NOP0);
        chk("ar_sc0", sc0, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        iv1 = 0; iv0 = 0;
        tick();

        rnd_cycles(800, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
